// File: rtl/branch_predict_unit_pkg.sv
// ============================================================================
// Module   : branch_predict_unit_pkg
// Brief    : BTB entry layout, counter encodings and tag helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package branch_predict_unit_pkg;

  localparam logic [1:0]  c_cnt_snt = 2'b00;
  localparam logic [1:0]  c_cnt_wnt = 2'b01;
  localparam logic [1:0]  c_cnt_wt  = 2'b10;
  localparam logic [1:0]  c_cnt_st  = 2'b11;
  localparam logic [31:0] c_pc_inc  = 32'd4;

  // Wide enough for any index width; unused upper bits stay zero.
  localparam int c_tag_w = 30;

  typedef struct packed {
    logic               valid;
    logic [c_tag_w-1:0] tag;
    logic [31:0]        target;
    logic [1:0]         cnt;
  } btb_entry_t;

  function automatic logic [c_tag_w-1:0] tag_of(input logic [31:0] addr, input int idx_bits);
    return c_tag_w'(addr >> (idx_bits + 2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_unit_sat_counter2.sv
// ============================================================================
// Module   : sat_counter2
// Brief    : 2-bit saturating up/down counter (next-value logic only).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_up,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_up) begin
      if (i_cnt != c_cnt_st) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != c_cnt_snt) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module   : branch_predict_unit
// Brief    : Direct-mapped BTB predictor with mispredict redirect to fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] InstrAddr,
  output logic [31:0] Predict,
  output logic        PCSource,
  input  logic        ResValid,
  input  logic [31:0] ResPC,
  input  logic        ResTaken,
  input  logic [31:0] ResTarget,
  input  logic        ResPredTaken,
  input  logic [31:0] ResPredTarget,
  output logic        FlushPipeandPC,
  output logic [31:0] JmpAddr,
  output logic [31:0] MispredCnt
);

  localparam int c_entries = 1 << IDX_BITS;

  btb_entry_t          w_btb [c_entries];
  btb_entry_t          w_lk_entry;
  btb_entry_t          w_res_entry;
  logic [IDX_BITS-1:0] w_lk_idx;
  logic [IDX_BITS-1:0] w_res_idx;
  logic                w_lk_hit;
  logic                w_res_hit;
  logic                w_accept;
  logic                w_mispred;
  logic                w_unused_addr_lsb;
  logic                r_flush;
  logic [31:0]         r_jmp;
  logic [31:0]         r_mcnt;

  assign w_unused_addr_lsb = ^InstrAddr[1:0];

  assign w_lk_idx   = InstrAddr[IDX_BITS+1:2];
  assign w_lk_entry = w_btb[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == tag_of(InstrAddr, IDX_BITS));

  assign PCSource = ~Rst & w_lk_hit & w_lk_entry.cnt[1];
  assign Predict  = (~Rst & w_lk_hit) ? w_lk_entry.target : 32'd0;

  // Resolutions arriving while a flush is out are from the wrong path.
  assign w_accept    = ResValid & ~r_flush;
  assign w_mispred   = (ResTaken != ResPredTaken) |
                       (ResTaken & ResPredTaken & (ResTarget != ResPredTarget));
  assign w_res_idx   = ResPC[IDX_BITS+1:2];
  assign w_res_entry = w_btb[w_res_idx];
  assign w_res_hit   = w_res_entry.valid && (w_res_entry.tag == tag_of(ResPC, IDX_BITS));

  for (genvar i = 0; i < c_entries; i++) begin : g_entry
    btb_entry_t r_entry;
    logic [1:0] w_cnt_next;
    logic       w_sel;

    assign w_sel = w_accept && (w_res_idx == IDX_BITS'(i));

    sat_counter2 u_cnt (
      .i_cnt (r_entry.cnt),
      .i_up  (ResTaken),
      .o_cnt (w_cnt_next)
    );

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_entry.valid  <= 1'b0;
        r_entry.tag    <= '0;
        r_entry.target <= '0;
        r_entry.cnt    <= c_cnt_wnt;
      end else if (w_sel) begin
        if (w_res_hit) begin
          r_entry.cnt <= w_cnt_next;
          if (ResTaken) r_entry.target <= ResTarget;
        end else if (ResTaken) begin
          r_entry.valid  <= 1'b1;
          r_entry.tag    <= tag_of(ResPC, IDX_BITS);
          r_entry.target <= ResTarget;
          r_entry.cnt    <= CNT_INIT;
        end
      end
    end

    assign w_btb[i] = r_entry;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_flush <= 1'b0;
      r_jmp   <= '0;
      r_mcnt  <= '0;
    end else begin
      r_flush <= w_accept & w_mispred;
      if (w_accept && w_mispred) begin
        r_jmp <= ResTaken ? ResTarget : (ResPC + c_pc_inc);
        if (r_mcnt != 32'hFFFF_FFFF) r_mcnt <= r_mcnt + 32'd1;
      end
    end
  end

  assign FlushPipeandPC = r_flush;
  assign JmpAddr        = r_jmp;
  assign MispredCnt     = r_mcnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Directed and randomized checks of branch_predict_unit vs a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] InstrAddr = 32'h100;
  logic [31:0] Predict;
  logic        PCSource;
  logic        ResValid = 1'b0;
  logic [31:0] ResPC = '0;
  logic        ResTaken = 1'b0;
  logic [31:0] ResTarget = '0;
  logic        ResPredTaken = 1'b0;
  logic [31:0] ResPredTarget = '0;
  logic        FlushPipeandPC;
  logic [31:0] JmpAddr;
  logic [31:0] MispredCnt;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  branch_predict_unit #(.IDX_BITS(4), .CNT_INIT(2'b10)) dut (
    .Clk(Clk), .Rst(Rst), .InstrAddr(InstrAddr), .Predict(Predict), .PCSource(PCSource),
    .ResValid(ResValid), .ResPC(ResPC), .ResTaken(ResTaken), .ResTarget(ResTarget),
    .ResPredTaken(ResPredTaken), .ResPredTarget(ResPredTarget),
    .FlushPipeandPC(FlushPipeandPC), .JmpAddr(JmpAddr), .MispredCnt(MispredCnt)
  );

  // Reference model: 16-entry table, tag = addr>>6, counter kept as an integer 0..3.
  localparam int NE = 16;
  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_cnt   [NE];
  logic        m_flush;
  logic [31:0] m_jmp;
  logic [31:0] m_mcnt;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % NE);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_flush = 1'b0; m_jmp = '0; m_mcnt = '0;
  endfunction

  function automatic void model_lookup(input logic [31:0] a, output logic src, output logic [31:0] pred);
    int  k;
    bit  hit;
    k    = idx_of(a);
    hit  = m_valid[k] && (m_tag[k] == (a >> 6));
    src  = hit && (m_cnt[k] >= 2);
    pred = hit ? m_tgt[k] : 32'd0;
  endfunction

  task automatic drive_res(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ResValid = v; ResPC = pc; ResTaken = t; ResTarget = tgt;
    ResPredTaken = pt; ResPredTarget = ptgt;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    bit acc, mis, hit;
    int k;
    @(posedge Clk);
    acc = ResValid && !m_flush;
    mis = (ResTaken != ResPredTaken) || (ResTaken && ResPredTaken && (ResTarget != ResPredTarget));
    m_flush = acc && mis;
    if (acc && mis) begin
      m_jmp = ResTaken ? ResTarget : ResPC + 32'd4;
      if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
    end
    if (acc) begin
      k   = idx_of(ResPC);
      hit = m_valid[k] && (m_tag[k] == (ResPC >> 6));
      if (hit) begin
        if (ResTaken) begin
          m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
          m_tgt[k] = ResTarget;
        end else begin
          m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        end
      end else if (ResTaken) begin
        m_valid[k] = 1; m_tag[k] = ResPC >> 6; m_tgt[k] = ResTarget; m_cnt[k] = 2;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; InstrAddr = 32'h100;
    #3;
    checks++; if (PCSource !== 1'b0) begin failures++; $display("FAIL rst_pcsource_held actual=%0h required=0", PCSource); end
    checks++; if (Predict !== 32'd0) begin failures++; $display("FAIL rst_predict_held actual=%0h required=0", Predict); end
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    checks++; if (PCSource !== 1'b0) begin failures++; $display("FAIL rst_pcsource actual=%0h required=0", PCSource); end
    checks++; if (Predict !== 32'd0) begin failures++; $display("FAIL rst_predict actual=%0h required=0", Predict); end
    checks++; if (FlushPipeandPC !== 1'b0) begin failures++; $display("FAIL rst_flush actual=%0h required=0", FlushPipeandPC); end
    checks++; if (MispredCnt !== 32'd0) begin failures++; $display("FAIL rst_mcnt actual=%0h required=0", MispredCnt); end
    checks++; if (JmpAddr !== 32'd0) begin failures++; $display("FAIL rst_jmp actual=%0h required=0", JmpAddr); end
  endtask

  task automatic test_allocate();
    drive_res(1, 32'h100, 1, 32'h200, 0, 32'h0);
    tick();
    checks++; if (FlushPipeandPC !== 1'b1) begin failures++; $display("FAIL alloc_flush actual=%0h required=1", FlushPipeandPC); end
    checks++; if (JmpAddr !== 32'h200) begin failures++; $display("FAIL alloc_jmp actual=%0h required=200", JmpAddr); end
    checks++; if (MispredCnt !== 32'd1) begin failures++; $display("FAIL alloc_mcnt actual=%0h required=1", MispredCnt); end
    drive_res(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (FlushPipeandPC !== 1'b0) begin failures++; $display("FAIL alloc_flush_one_cycle actual=%0h required=0", FlushPipeandPC); end
    InstrAddr = 32'h100; #1;
    checks++; if (PCSource !== 1'b1) begin failures++; $display("FAIL alloc_pcsource actual=%0h required=1", PCSource); end
    checks++; if (Predict !== 32'h200) begin failures++; $display("FAIL alloc_predict actual=%0h required=200", Predict); end
  endtask

  task automatic test_train_down();
    for (int n = 0; n < 2; n++) begin
      drive_res(1, 32'h100, 0, 32'h200, 1, 32'h200);
      tick();
      checks++; if (FlushPipeandPC !== 1'b1) begin failures++; $display("FAIL down_flush%0d actual=%0h required=1", n, FlushPipeandPC); end
      checks++; if (JmpAddr !== 32'h104) begin failures++; $display("FAIL down_jmp%0d actual=%0h required=104", n, JmpAddr); end
      drive_res(0, 0, 0, 0, 0, 0);
      tick();
    end
    InstrAddr = 32'h100; #1;
    checks++; if (PCSource !== 1'b0) begin failures++; $display("FAIL down_pcsource actual=%0h required=0", PCSource); end
    checks++; if (MispredCnt !== 32'd3) begin failures++; $display("FAIL down_mcnt actual=%0h required=3", MispredCnt); end
  endtask

  task automatic test_alias();
    drive_res(1, 32'h140, 1, 32'h300, 0, 32'h0);
    tick();
    checks++; if (JmpAddr !== 32'h300) begin failures++; $display("FAIL alias_jmp actual=%0h required=300", JmpAddr); end
    drive_res(0, 0, 0, 0, 0, 0);
    tick();
    InstrAddr = 32'h100; #1;
    checks++; if (PCSource !== 1'b0 || Predict !== 32'd0) begin failures++; $display("FAIL alias_old_miss actual=%0h/%0h required=0/0", PCSource, Predict); end
    InstrAddr = 32'h140; #1;
    checks++; if (PCSource !== 1'b1 || Predict !== 32'h300) begin failures++; $display("FAIL alias_new_hit actual=%0h/%0h required=1/300", PCSource, Predict); end
  endtask

  task automatic test_correct_predict();
    for (int n = 0; n < 3; n++) begin
      drive_res(1, 32'h140, 1, 32'h300, 1, 32'h300);
      tick();
      checks++; if (FlushPipeandPC !== 1'b0 || MispredCnt !== 32'd4) begin
        failures++; $display("FAIL correct_noflush%0d actual=%0h/%0h required=0/4", n, FlushPipeandPC, MispredCnt); end
    end
    // One correctly-predicted not-taken step from a saturated counter must stay weakly taken.
    drive_res(1, 32'h140, 0, 32'h0, 0, 32'h0);
    tick();
    drive_res(0, 0, 0, 0, 0, 0);
    InstrAddr = 32'h140; #1;
    checks++; if (PCSource !== 1'b1) begin failures++; $display("FAIL correct_saturate actual=%0h required=1", PCSource); end
    drive_res(1, 32'h184, 1, 32'h400, 0, 32'h0);
    tick();
    checks++; if (FlushPipeandPC !== 1'b1 || MispredCnt !== 32'd5) begin
      failures++; $display("FAIL flushcyc_setup actual=%0h/%0h required=1/5", FlushPipeandPC, MispredCnt); end
    drive_res(1, 32'h188, 1, 32'h500, 0, 32'h0);
    tick();
    drive_res(0, 0, 0, 0, 0, 0);
    checks++; if (FlushPipeandPC !== 1'b0 || MispredCnt !== 32'd5 || JmpAddr !== 32'h400) begin
      failures++; $display("FAIL flushcyc_ignored actual=%0h/%0h/%0h required=0/5/400", FlushPipeandPC, MispredCnt, JmpAddr); end
    InstrAddr = 32'h188; #1;
    checks++; if (PCSource !== 1'b0 || Predict !== 32'd0) begin failures++; $display("FAIL flushcyc_no_train actual=%0h/%0h required=0/0", PCSource, Predict); end
    InstrAddr = 32'h184; #1;
    checks++; if (PCSource !== 1'b1 || Predict !== 32'h400) begin failures++; $display("FAIL flushcyc_prev_entry actual=%0h/%0h required=1/400", PCSource, Predict); end
  endtask

  task automatic test_target_wrap();
    drive_res(1, 32'h184, 1, 32'h480, 1, 32'h400);
    tick();
    checks++; if (FlushPipeandPC !== 1'b1 || JmpAddr !== 32'h480) begin
      failures++; $display("FAIL target_mismatch actual=%0h/%0h required=1/480", FlushPipeandPC, JmpAddr); end
    drive_res(0, 0, 0, 0, 0, 0);
    tick();
    drive_res(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);
    tick();
    checks++; if (FlushPipeandPC !== 1'b1 || JmpAddr !== 32'h0) begin
      failures++; $display("FAIL pc_wrap actual=%0h/%0h required=1/0", FlushPipeandPC, JmpAddr); end
    drive_res(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 32'h100;
      1:       return 32'h140;
      2:       return 32'h104;
      3:       return 32'h144;
      4:       return 32'h184;
      5:       return 32'hFFFF_FFFC;
      6:       return 32'h1C0;
      default: return 32'($urandom_range(0, 1023)) << 2;
    endcase
  endfunction

  task automatic test_random();
    logic        es, ps;
    logic [31:0] ep, pp;
    for (int n = 0; n < 400; n++) begin
      InstrAddr = pick_addr();
      ResValid  = ($urandom_range(0, 3) != 0);
      ResPC     = pick_addr();
      ResTaken  = 1'($urandom_range(0, 1));
      ResTarget = pick_addr();
      model_lookup(ResPC, ps, pp);
      if ($urandom_range(0, 3) != 0) begin
        ResPredTaken = ps; ResPredTarget = pp;
      end else begin
        ResPredTaken = 1'($urandom_range(0, 1)); ResPredTarget = pick_addr();
      end
      #1;
      model_lookup(InstrAddr, es, ep);
      checks++; if (PCSource !== es || Predict !== ep) begin
        failures++; $display("FAIL rnd_lookup%0d addr=%0h actual=%0h/%0h required=%0h/%0h", n, InstrAddr, PCSource, Predict, es, ep); end
      tick();
      checks++; if (FlushPipeandPC !== m_flush || JmpAddr !== m_jmp || MispredCnt !== m_mcnt) begin
        failures++; $display("FAIL rnd_redirect%0d actual=%0h/%0h/%0h required=%0h/%0h/%0h", n,
                             FlushPipeandPC, JmpAddr, MispredCnt, m_flush, m_jmp, m_mcnt); end
    end
    drive_res(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midflush();
    drive_res(1, 32'h144, 1, 32'h600, 0, 32'h0);
    tick();
    checks++; if (FlushPipeandPC !== 1'b1) begin failures++; $display("FAIL midrst_setup actual=%0h required=1", FlushPipeandPC); end
    drive_res(0, 0, 0, 0, 0, 0);
    InstrAddr = 32'h144;
    #1 Rst = 1'b1;
    #1;
    checks++; if (FlushPipeandPC !== 1'b0) begin failures++; $display("FAIL midrst_async_drop actual=%0h required=0", FlushPipeandPC); end
    checks++; if (PCSource !== 1'b0) begin failures++; $display("FAIL midrst_pcsource actual=%0h required=0", PCSource); end
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    model_reset();
    #1;
    checks++; if (PCSource !== 1'b0 || Predict !== 32'd0) begin failures++; $display("FAIL midrst_invalid actual=%0h/%0h required=0/0", PCSource, Predict); end
    checks++; if (MispredCnt !== 32'd0 || JmpAddr !== 32'd0) begin failures++; $display("FAIL midrst_regs actual=%0h/%0h required=0/0", MispredCnt, JmpAddr); end
    tick();
    checks++; if (FlushPipeandPC !== 1'b0) begin failures++; $display("FAIL midrst_after actual=%0h required=0", FlushPipeandPC); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_allocate();
    test_train_down();
    test_alias();
    test_correct_predict();
    test_target_wrap();
    test_random();
    test_reset_midflush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
